// File: rtl/reg_file.sv
// reg_file -- dual-read, single-write register file feeding the operand-select mux.
//
// Purpose:
//   2**ADDR_WIDTH words of DATA_WIDTH bits. Entry 0 always reads as zero.
//   Read data is registered, so rdData0/rdData1 can drive the mux inCh0/inCh1
//   inputs directly. No combinational path from any input to any output.
//
// Optional feature (macro REG_FILE_BYPASS_EN):
//   defined   -> a read and a write that hit the same nonzero entry on the same
//                edge return the new (written) value.
//   undefined -> the same case returns the entry's old value.
//
// Ports:
//   clk      in   1           rising-edge clock
//   rst      in   1           asynchronous, active-high reset
//   rdEn     in   1           sample both read addresses this edge
//   rdAddr0  in   ADDR_WIDTH  read port 0 address
//   rdAddr1  in   ADDR_WIDTH  read port 1 address
//   wrEn     in   1           write strobe
//   wrAddr   in   ADDR_WIDTH  write address (0 = discarded)
//   wrData   in   DATA_WIDTH  write data
//   rdData0  out  DATA_WIDTH  registered read data, port 0
//   rdData1  out  DATA_WIDTH  registered read data, port 1
//   rdValid  out  1           one-cycle pulse per accepted read
//
// Handshake: there is no backpressure. A read is accepted on every edge where
// rdEn=1; rdValid is high for exactly the cycle after that edge, and
// rdData0/rdData1 hold the result until the next accepted read (they are
// stable, not cleared, while rdEn=0).

module reg_file #(
  parameter int DATA_WIDTH = 32,
  parameter int ADDR_WIDTH = 5
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  rdEn,
  input  logic [ADDR_WIDTH-1:0] rdAddr0,
  input  logic [ADDR_WIDTH-1:0] rdAddr1,
  input  logic                  wrEn,
  input  logic [ADDR_WIDTH-1:0] wrAddr,
  input  logic [DATA_WIDTH-1:0] wrData,
  output logic [DATA_WIDTH-1:0] rdData0,
  output logic [DATA_WIDTH-1:0] rdData1,
  output logic                  rdValid
);

  localparam int DEPTH = 2 ** ADDR_WIDTH;
  localparam logic [ADDR_WIDTH-1:0] ZERO_ADDR = '0;

  logic [DATA_WIDTH-1:0] r_mem [DEPTH];
  logic [DATA_WIDTH-1:0] r_rd_data0;
  logic [DATA_WIDTH-1:0] r_rd_data1;
  logic                  r_rd_valid;

  logic                  w_wr_hit;
  logic [DATA_WIDTH-1:0] w_rd_next0;
  logic [DATA_WIDTH-1:0] w_rd_next1;

  // Writes to address 0 are dropped so entry 0 never leaves its reset value.
  assign w_wr_hit = wrEn && (wrAddr != ZERO_ADDR);

  // Next read values. Address 0 is forced to zero ahead of any bypass so a
  // same-edge write to 0 can never leak through.
  always_comb begin
    w_rd_next0 = '0;
    w_rd_next1 = '0;
    if (rdAddr0 != ZERO_ADDR) begin
      w_rd_next0 = r_mem[rdAddr0];
`ifdef REG_FILE_BYPASS_EN
      if (w_wr_hit && (wrAddr == rdAddr0)) w_rd_next0 = wrData;
`endif
    end
    if (rdAddr1 != ZERO_ADDR) begin
      w_rd_next1 = r_mem[rdAddr1];
`ifdef REG_FILE_BYPASS_EN
      if (w_wr_hit && (wrAddr == rdAddr1)) w_rd_next1 = wrData;
`endif
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < DEPTH; i++) r_mem[i] <= '0;
      r_rd_data0 <= '0;
      r_rd_data1 <= '0;
      r_rd_valid <= 1'b0;
    end else begin
      if (w_wr_hit) r_mem[wrAddr] <= wrData;
      r_rd_valid <= rdEn;
      if (rdEn) begin
        r_rd_data0 <= w_rd_next0;
        r_rd_data1 <= w_rd_next1;
      end
    end
  end

  assign rdData0 = r_rd_data0;
  assign rdData1 = r_rd_data1;
  assign rdValid = r_rd_valid;

endmodule
